// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute-stage M-extension unit.
//   XLEN         operand/result width, also the iteration count
//   F3_*         funct3 encodings of the RV32M operations
//   ST_*         FSM state encodings of ex_muldiv_unit
//   abs_if()     magnitude of a value when it is to be treated as signed
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    // Negation is modulo 2^XLEN, so the most negative value maps onto
    // itself and is then used as an unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v,
                                               input logic            sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (sgn && v[XLEN-1]) r = ~v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply / restoring divide datapath.
//   mode_i   0: multiply step, 1: divide step
//   part_i   partial value, 2*XLEN bits
//            multiply: {running high sum, remaining multiplier bits}
//            divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd_i   multiplicand (multiply) or divisor (divide)
//   part_o   next partial value; in divide mode bit 0 is left clear
//   qbit_o   quotient bit produced this step (0 in multiply mode)
module muldiv_step
    import pipeline_pkg::*;
(
    input  logic                mode_i,
    input  logic [2*XLEN-1:0]   part_i,
    input  logic [XLEN-1:0]     opnd_i,
    output logic [2*XLEN-1:0]   part_o,
    output logic                qbit_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, part_i[2*XLEN-1:XLEN]} + (part_i[0] ? {1'b0, opnd_i} : '0);
        // Remainder shifted left with the next dividend bit brought in.
        shifted = part_i[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opnd_i};
        part_o  = '0;
        qbit_o  = 1'b0;
        if (mode_i) begin
            // No borrow means the divisor fits: keep the difference.
            qbit_o = ~diff[XLEN];
            part_o = {(qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0]),
                      part_i[XLEN-2:0], 1'b0};
        end else begin
            // Carry out of the add lands in the top bit as the product shifts right.
            part_o = {sum, part_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one bit
// per cycle, fixed latency.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pipeline latch holds a valid M-op
//   kill             flush; aborts any operation, wins over start
//   funct3           operation select
//   rs1_data         operand A (multiplicand / dividend)
//   rs2_data         operand B (multiplier / divisor)
//   rd               destination register, carried to rd_out
//   busy             operation accepted and not yet done
//   done             one-cycle pulse qualifying result/rd_out
//   result, rd_out   registered output, held outside done
//   dbg_state        current FSM state
// Handshake: start is sampled only in IDLE; busy is high from the cycle after
// acceptance until the cycle before done; done lasts exactly one cycle and a
// start presented during it is accepted without a bubble.
module ex_muldiv_unit
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              kill,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        rd_out,
    output logic [1:0]        dbg_state
);

    localparam int CW = $clog2(XLEN);

    logic [1:0]          state_q,  state_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [2:0]          op_q,     op_d;
    logic [4:0]          rd_q,     rd_d;
    logic [XLEN-1:0]     opnd_q,   opnd_d;
    logic [2*XLEN-1:0]   acc_q,    acc_d;
    logic                neg_q,    neg_d;   // product / quotient negative
    logic                sa_q,     sa_d;    // signed dividend was negative
    logic                div0_q,   div0_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_out_q, rd_out_d;
    logic                done_q,   done_d;

    logic [2*XLEN-1:0]   step_part;
    logic                step_qbit;
    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    muldiv_step u_step (
        .mode_i (op_q[2]),
        .part_i (acc_q),
        .opnd_i (opnd_q),
        .part_o (step_part),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        div0_d   = div0_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        abs_a = abs_if(rs1_data, a_sgn);
        abs_b = abs_if(rs2_data, b_sgn);

        prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        // With a zero divisor the remainder is |A| and re-applying the
        // dividend sign restores rs1_data exactly, so no special case here.
        rem  = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d   = funct3;
                        rd_d   = rd;
                        neg_d  = (a_sgn & rs1_data[XLEN-1]) ^ (b_sgn & rs2_data[XLEN-1]);
                        sa_d   = a_sgn & rs1_data[XLEN-1];
                        div0_d = (rs2_data == '0);
                        cnt_d  = '0;
                        if (funct3[2]) begin
                            opnd_d = abs_b;
                            acc_d  = {{XLEN{1'b0}}, abs_a};
                        end else begin
                            opnd_d = abs_a;
                            acc_d  = {{XLEN{1'b0}}, abs_b};
                        end
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_d = step_part | {{(2*XLEN-1){1'b0}}, step_qbit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) state_d = ST_FIN;
                end
                ST_FIN: begin
                    case (op_q)
                        F3_MUL:                      result_d = prod[XLEN-1:0];
                        F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod[2*XLEN-1:XLEN];
                        F3_DIV:                      result_d = div0_q ? '1 : quo;
                        F3_DIVU:                     result_d = div0_q ? '1 : acc_q[XLEN-1:0];
                        default:                     result_d = rem;
                    endcase
                    rd_out_d = rd_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            div0_q   <= div0_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign rd_out    = rd_out_q;
    assign dbg_state = state_q;

endmodule
